// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - byte transfer controller between TX/RX FIFOs and an SPI master req/ack handshake
module spi_xfer_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    input  logic                     flush,
    input  logic                     clr_err,
    output logic                     tx_full,
    output logic                     tx_empty,
    output logic                     rx_full,
    output logic                     rx_empty,
    output logic [$clog2(DEPTH):0]   tx_cnt,
    output logic [$clog2(DEPTH):0]   rx_cnt,
    output logic                     tx_ovf,
    output logic                     rx_udf,
    output logic                     busy,
    output logic [7:0]               m_tx_data,
    output logic                     m_tx_req,
    input  logic                     m_tx_req_ack,
    input  logic [7:0]               m_rx_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE_s, REQ_s, REL_s} state_t;

    state_t          state, state_n;
    logic            req_n;
    logic            start;
    logic            ack_edge;
    logic [7:0]      tx_hold;
    logic            discard;

    logic [7:0]      tx_mem [DEPTH];
    logic [7:0]      rx_mem [DEPTH];
    logic [PW-1:0]   tx_wptr, tx_rptr, rx_wptr, rx_rptr;

    logic            tx_push, tx_pop, rx_push, rx_pop;

    assign tx_full   = (tx_cnt == FULL_CNT);
    assign tx_empty  = (tx_cnt == '0);
    assign rx_full   = (rx_cnt == FULL_CNT);
    assign rx_empty  = (rx_cnt == '0);
    assign rd_data   = rx_mem[rx_rptr];
    assign m_tx_data = tx_hold;
    assign busy      = (state != IDLE_s);

    // A write into a full FIFO is dropped even if the FSM pops that same cycle
    assign tx_push = wr_en && !tx_full && !flush;
    assign tx_pop  = start;
    assign rx_push = ack_edge && !flush && !discard;
    assign rx_pop  = rd_en && !rx_empty && !flush;

    always_comb begin
        state_n  = state;
        req_n    = m_tx_req;
        start    = 1'b0;
        ack_edge = 1'b0;
        case (state)
            IDLE_s: begin
                // Holding off on a full RX FIFO guarantees the returned byte always has a slot
                if (!tx_empty && !m_tx_req_ack && !rx_full && !flush) begin
                    start   = 1'b1;
                    req_n   = 1'b1;
                    state_n = REQ_s;
                end
            end
            REQ_s: begin
                if (m_tx_req_ack) begin
                    ack_edge = 1'b1;
                    req_n    = 1'b0;
                    state_n  = REL_s;
                end
            end
            REL_s: begin
                if (!m_tx_req_ack) begin
                    state_n = IDLE_s;
                end
            end
            default: state_n = IDLE_s;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE_s;
            m_tx_req <= 1'b0;
            tx_hold  <= 8'h00;
            discard  <= 1'b0;
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_cnt   <= '0;
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_cnt   <= '0;
            tx_ovf   <= 1'b0;
            rx_udf   <= 1'b0;
        end else begin
            state    <= state_n;
            m_tx_req <= req_n;
            if (start) begin
                tx_hold <= tx_mem[tx_rptr];
            end
            // A flush during REQ_s lets the handshake finish but drops its returned byte
            if (ack_edge) begin
                discard <= 1'b0;
            end else if (flush && state == REQ_s) begin
                discard <= 1'b1;
            end
            if (flush) begin
                tx_wptr <= '0;
                tx_rptr <= '0;
                tx_cnt  <= '0;
                rx_wptr <= '0;
                rx_rptr <= '0;
                rx_cnt  <= '0;
            end else begin
                if (tx_push) tx_wptr <= tx_wptr + 1'b1;
                if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
                if (rx_push) rx_wptr <= rx_wptr + 1'b1;
                if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
                tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
                rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
            end
            tx_ovf <= (tx_ovf && !clr_err) || (wr_en && tx_full);
            rx_udf <= (rx_udf && !clr_err) || (rd_en && rx_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= wr_data;
        if (rx_push) rx_mem[rx_wptr] <= m_rx_data;
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - self-checking bench for spi_xfer_ctrl with a reactive SPI master model
module tb_spi_xfer_ctrl;

    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          rd_en = 1'b0;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic          m_tx_req_ack = 1'b0;
    logic [7:0]    m_rx_data = 8'h00;
    logic [7:0]    rd_data;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          tx_ovf, rx_udf, busy;
    logic [7:0]    m_tx_data;
    logic          m_tx_req;

    int n_chk = 0;
    int n_fail = 0;

    bit         master_en = 1'b0;
    int         ack_delay = 2;
    bit         use_fixed = 1'b0;
    logic [7:0] fixed_resp = 8'h00;

    logic [7:0] sent_q[$];
    logic [7:0] resp_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] rx_got[$];

    spi_xfer_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .flush(flush), .clr_err(clr_err),
        .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
        .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .tx_ovf(tx_ovf), .rx_udf(rx_udf), .busy(busy),
        .m_tx_data(m_tx_data), .m_tx_req(m_tx_req), .m_tx_req_ack(m_tx_req_ack),
        .m_rx_data(m_rx_data)
    );

    always #5 clk = ~clk;

    // SPI master model: ack after ack_delay cycles, release once the request drops
    always begin
        logic [7:0] resp;
        @(negedge clk);
        if (master_en && m_tx_req && !m_tx_req_ack) begin
            repeat (ack_delay) @(negedge clk);
            if (m_tx_req) begin
                resp = use_fixed ? fixed_resp : 8'($urandom_range(0, 255));
                m_rx_data = resp;
                m_tx_req_ack = 1'b1;
                sent_q.push_back(m_tx_data);
                resp_q.push_back(resp);
                for (int i = 0; i < 100 && m_tx_req; i++) @(negedge clk);
                m_tx_req_ack = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit q_eq(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_sb();
        sent_q.delete();
        resp_q.delete();
        exp_tx_q.delete();
        rx_got.delete();
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain(input int n);
        int got = 0;
        for (int c = 0; c < 400 && got < n; c++) begin
            rd_en = !rx_empty;
            if (!rx_empty) begin
                rx_got.push_back(rd_data);
                got++;
            end
            @(negedge clk);
        end
        rd_en = 1'b0;
    endtask

    task automatic wait_for_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!busy && tx_empty) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_chk++;
        if ({m_tx_req, busy, tx_empty, rx_empty, tx_full, rx_full, tx_ovf, rx_udf} !== 8'b0011_0000) begin
            n_fail++;
            $display("FAIL reset_flags: req,busy,te,re,tf,rf,ovf,udf=%b expected 00110000",
                     {m_tx_req, busy, tx_empty, rx_empty, tx_full, rx_full, tx_ovf, rx_udf});
        end
        n_chk++;
        if (tx_cnt !== '0 || rx_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_counts: tx_cnt=%0d rx_cnt=%0d expected 0 0", tx_cnt, rx_cnt);
        end
        n_chk++;
        if (m_tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_tx_data: m_tx_data=%h expected 00", m_tx_data);
        end
    endtask

    task automatic test_single_byte();
        bit ok;
        clear_sb();
        master_en = 1'b1;
        ack_delay = 20;
        use_fixed = 1'b1;
        fixed_resp = 8'h3C;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        n_chk++;
        if (m_tx_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_req_early: m_tx_req=%b after edge N expected 0", m_tx_req);
        end
        @(negedge clk);
        n_chk++;
        if (m_tx_req !== 1'b1 || m_tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_req_rise: m_tx_req=%b m_tx_data=%h expected 1 a5", m_tx_req, m_tx_data);
        end
        wait_for_idle(ok);
        n_chk++;
        if (!ok || rx_cnt !== CW'(1) || rd_data !== 8'h3C || tx_empty !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: ok=%b rx_cnt=%0d rd_data=%h tx_empty=%b busy=%b expected 1 1 3c 1 0",
                     ok, rx_cnt, rd_data, tx_empty, busy);
        end
        drain(1);
        use_fixed = 1'b0;
        n_chk++;
        if (rx_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL single_pop: rx_empty=%b expected 1", rx_empty);
        end
    endtask

    task automatic test_tx_overflow();
        clear_sb();
        master_en = 1'b0;
        for (int b = 1; b <= 6; b++) begin
            write_byte(8'(b));
            if (b <= 5) exp_tx_q.push_back(8'(b));
        end
        n_chk++;
        if (m_tx_req !== 1'b1 || m_tx_data !== 8'h01) begin
            n_fail++;
            $display("FAIL ovf_hold: m_tx_req=%b m_tx_data=%h expected 1 01", m_tx_req, m_tx_data);
        end
        n_chk++;
        if (tx_cnt !== CW'(DEPTH) || tx_full !== 1'b1 || tx_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flags: tx_cnt=%0d tx_full=%b tx_ovf=%b expected %0d 1 1",
                     tx_cnt, tx_full, tx_ovf, DEPTH);
        end
        ack_delay = $urandom_range(0, 3);
        master_en = 1'b1;
        drain(5);
        n_chk++;
        if (!q_eq(sent_q, exp_tx_q)) begin
            n_fail++;
            $display("FAIL ovf_order: %0d bytes sent, first=%h; expected 01..05",
                     sent_q.size(), (sent_q.size() > 0) ? sent_q[0] : 8'hxx);
        end
        n_chk++;
        if (!q_eq(rx_got, resp_q)) begin
            n_fail++;
            $display("FAIL ovf_rx_data: read %0d bytes, expected %0d matching master responses",
                     rx_got.size(), resp_q.size());
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_chk++;
        if (tx_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: tx_ovf=%b expected 0", tx_ovf);
        end
    endtask

    task automatic test_rx_backpressure();
        bit req_seen = 1'b0;
        bit saw = 1'b0;
        clear_sb();
        ack_delay = $urandom_range(0, 2);
        master_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            exp_tx_q.push_back(b);
            write_byte(b);
        end
        for (int c = 0; c < 200 && !rx_full; c++) @(negedge clk);
        repeat (10) begin
            @(negedge clk);
            if (m_tx_req) req_seen = 1'b1;
        end
        n_chk++;
        if (rx_full !== 1'b1 || rx_cnt !== CW'(DEPTH) || tx_cnt !== CW'(1)) begin
            n_fail++;
            $display("FAIL bp_full: rx_full=%b rx_cnt=%0d tx_cnt=%0d expected 1 %0d 1",
                     rx_full, rx_cnt, tx_cnt, DEPTH);
        end
        n_chk++;
        if (req_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: m_tx_req seen=%b while rx full, expected 0", req_seen);
        end
        rx_got.push_back(rd_data);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        for (int c = 0; c < 2 && !saw; c++) begin
            if (m_tx_req) saw = 1'b1;
            else @(negedge clk);
        end
        n_chk++;
        if (saw !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_resume: m_tx_req within 2 clocks=%b expected 1", saw);
        end
        drain(4);
        n_chk++;
        if (!q_eq(sent_q, exp_tx_q) || !q_eq(rx_got, resp_q)) begin
            n_fail++;
            $display("FAIL bp_order: sent=%0d rx=%0d resp=%0d, expected 5 in-order transfers",
                     sent_q.size(), rx_got.size(), resp_q.size());
        end
    endtask

    task automatic test_flush_mid();
        bit ok;
        clear_sb();
        ack_delay = 6;
        master_en = 1'b1;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        n_chk++;
        if (m_tx_req !== 1'b1 || tx_cnt !== CW'(2)) begin
            n_fail++;
            $display("FAIL flush_pre: m_tx_req=%b tx_cnt=%0d expected 1 2", m_tx_req, tx_cnt);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_chk++;
        if (tx_cnt !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_now: tx_cnt=%0d busy=%b expected 0 1", tx_cnt, busy);
        end
        wait_for_idle(ok);
        repeat (3) @(negedge clk);
        n_chk++;
        if (!ok || sent_q.size() != 1 || rx_cnt !== '0 || tx_cnt !== '0 || m_tx_req !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_done: ok=%b sent=%0d rx_cnt=%0d tx_cnt=%0d req=%b expected 1 1 0 0 0",
                     ok, sent_q.size(), rx_cnt, tx_cnt, m_tx_req);
        end
    endtask

    task automatic test_error_flags();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        n_chk++;
        if (rx_udf !== 1'b1 || rx_cnt !== '0) begin
            n_fail++;
            $display("FAIL udf_set: rx_udf=%b rx_cnt=%0d expected 1 0", rx_udf, rx_cnt);
        end
        rd_en = 1'b1;
        clr_err = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        n_chk++;
        if (rx_udf !== 1'b1) begin
            n_fail++;
            $display("FAIL udf_clr_collide: rx_udf=%b expected 1", rx_udf);
        end
        @(negedge clk);
        clr_err = 1'b0;
        n_chk++;
        if (rx_udf !== 1'b0) begin
            n_fail++;
            $display("FAIL udf_clear: rx_udf=%b expected 0", rx_udf);
        end
    endtask

    task automatic test_async_reset();
        clear_sb();
        ack_delay = 40;
        master_en = 1'b1;
        write_byte(8'h5A);
        for (int c = 0; c < 10 && !m_tx_req; c++) @(negedge clk);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_chk++;
        if (m_tx_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_now: m_tx_req=%b busy=%b expected 0 0", m_tx_req, busy);
        end
        @(posedge clk);
        @(negedge clk);
        test_reset();
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        n_chk++;
        if (tx_empty !== 1'b1 || busy !== 1'b0 || m_tx_req !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_after: tx_empty=%b busy=%b req=%b expected 1 0 0", tx_empty, busy, m_tx_req);
        end
    endtask

    task automatic test_random_stream();
        bit ok;
        clear_sb();
        master_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            ack_delay = $urandom_range(0, 4);
            wr_en = (($urandom % 3) == 0) && !tx_full;
            if (wr_en) begin
                wr_data = 8'($urandom_range(0, 255));
                exp_tx_q.push_back(wr_data);
            end
            rd_en = !rx_empty && ($urandom % 2 == 1);
            if (rd_en) rx_got.push_back(rd_data);
            @(negedge clk);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        wait_for_idle(ok);
        drain(resp_q.size() - rx_got.size());
        n_chk++;
        if (!ok || !q_eq(sent_q, exp_tx_q)) begin
            n_fail++;
            $display("FAIL rand_tx: ok=%b sent=%0d expected %0d bytes in write order",
                     ok, sent_q.size(), exp_tx_q.size());
        end
        n_chk++;
        if (!q_eq(rx_got, resp_q)) begin
            n_fail++;
            $display("FAIL rand_rx: read=%0d expected %0d bytes in response order", rx_got.size(), resp_q.size());
        end
        n_chk++;
        if (tx_ovf !== 1'b0 || rx_udf !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_flags: tx_ovf=%b rx_udf=%b expected 0 0", tx_ovf, rx_udf);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        resetn = 1'b1;
        @(negedge clk);
        test_single_byte();
        test_tx_overflow();
        test_rx_backpressure();
        test_flush_mid();
        test_error_flags();
        test_async_reset();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
